id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline boundary directly downstream of the opcode decoder (controller).
- Registers the decoder's control bundle together with the decoded operands into the EX stage.
- Performs load-use hazard detection and inserts a bubble when one is found.
- Honours branch/jump flush and downstream hold, and drives the upstream stall to the PC/IF-ID registers.

Parameters:
- XLEN, 32, datapath width of PC, operands and immediate.
- REGW, 5, register index width.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- id_valid  in  1  ID holds a real instruction.
- id_alusrc, id_memtoreg, id_regwrite, id_memread, id_memwrite, id_branch, id_jalsel, id_jalrsel  in  1 each  decoder control bits.
- id_aluop  in  2  decoder ALUOp (00 LW/SW, 01 branch/jump, 10 R/I, 11 LUI).
- id_pc, id_rd1, id_rd2, id_imm  in  XLEN each  PC, register-file read data, immediate.
- id_rs1, id_rs2, id_rd  in  REGW each  register indices.
- id_funct3  in  3  instruction funct3.
- id_funct7  in  7  instruction funct7.
- flush_i  in  1  branch/jump taken; the instruction in ID is wrong-path.
- ex_hold_i  in  1  EX cannot accept a new instruction (multi-cycle op).
- ex_* outputs  out  same widths as the id_* inputs  registered copies (ex_valid, ex_alusrc … ex_funct7).
- stall_o  out  1  combinational; freezes PC and IF/ID.

Behaviour:
- Reset: all ex_* outputs are 0, so ex_valid=0 and every control bit is 0 (bubble). stall_o follows its equation; it is 0 when ex_hold_i=0.
- Latency: 1 cycle from id_* to ex_*.
- rs1_used = !(id_aluop==2'b11) && !(id_jalsel && !id_jalrsel).
- rs2_used = (!id_alusrc && !id_jalsel) || id_memwrite.
- load_use = id_valid && ex_valid && ex_memread && ex_rd!=0 && ((rs1_used && ex_rd==id_rs1) || (rs2_used && ex_rd==id_rs2)).
- stall_o = ex_hold_i || (load_use && !flush_i).
- Per-edge priority (first match wins):
  1. reset: all ex_* cleared.
  2. flush_i: load a bubble. ex_valid=0 and all control bits 0. Data fields are don't-care but are cleared to 0. Applies even when ex_hold_i=1.
  3. ex_hold_i: all ex_* hold their value.
  4. load_use: load a bubble. ID is frozen by stall_o and re-presented on the next cycle.
  5. otherwise: load all id_* into ex_*.
- Loading with id_valid=0: all control bits are forced to 0, so a bubble never writes registers or memory.
- No state machine beyond the register itself. Each load-use stall lasts exactly one cycle, because the bubble clears ex_memread.
- Reset mid-stall: stall_o drops on the following cycle (it is 0 once ex_memread=0, provided ex_hold_i=0).
- rd=x0 never triggers a stall.

Optional Feature:
- Macro: ID_EX_PERF_CNT_EN.
- When defined, adds two output ports:
  - bubble_cnt, 32 bits: increments on every load-use bubble.
  - flush_cnt, 32 bits: increments on every flush edge.
- Both counters saturate at all-ones and clear on reset.
- When undefined, the ports and counters are absent and functionality is otherwise identical.

Decomposition:
- Package pipeline_pkg:
  - XLEN and REGW constants.
  - ALUOp encodings: ALUOP_MEM=2'b00, ALUOP_BR=2'b01, ALUOP_R=2'b10, ALUOP_LUI=2'b11.
  - ctrl_t packed struct holding the nine control bits plus aluop; the register stores it as one field.
  - Constant CTRL_BUBBLE = '0.
- Sub-module hazard_detect: purely combinational. Computes rs1_used, rs2_used, load_use and stall_o.

Test Plan:
- Reset: hold reset high for 2 cycles with id_valid=1 and id_regwrite=1 → ex_valid=0, ex_regwrite=0, all ex_* 0; after release, the next id_* appear on ex_* one cycle later.
- Load-use stall: lw x5 into EX (ex_memread=1, ex_rd=5), then add with rs1=5 in ID → stall_o=1 for exactly 1 cycle; ex_valid=0 on the next edge; the add reaches EX one cycle later with unchanged fields.
- No false stall:
  - lw x0 followed by a consumer of x0 → stall_o=0.
  - lw x5 followed by lui x7 with id_rs1=5 (ALUOp 11) → stall_o=0.
  - lw x5 followed by addi with id_rs2=5 (ALUSrc=1) → stall_o=0.
- sw store-data hazard: lw x6, then sw with rs2=6 and rs1=2 → stall_o=1 (rs2_used via memwrite).
- Flush priority: flush_i=1 together with load_use=1 and ex_hold_i=1 → stall_o=1 (from the hold), and on the next edge ex_valid=0 with all control bits 0.
- Hold: ex_hold_i=1 for 3 cycles while id_* changes → ex_* remain constant and stall_o=1; with the macro enabled, bubble_cnt and flush_cnt are unchanged.

Source files
------------

// File: rtl/pipeline_pkg.sv
`default_nettype none
// ============================================================================
// Module : pipeline_pkg
// Desc   : Shared widths, ALUOp encodings and the ID/EX control bundle.
// Rev    : 1.0
// ============================================================================
package pipeline_pkg;

    localparam int XLEN = 32;
    localparam int REGW = 5;

    localparam logic [1:0] ALUOP_MEM = 2'b00;
    localparam logic [1:0] ALUOP_BR  = 2'b01;
    localparam logic [1:0] ALUOP_R   = 2'b10;
    localparam logic [1:0] ALUOP_LUI = 2'b11;

    typedef struct packed {
        logic       valid;
        logic       alusrc;
        logic       memtoreg;
        logic       regwrite;
        logic       memread;
        logic       memwrite;
        logic       branch;
        logic       jalsel;
        logic       jalrsel;
        logic [1:0] aluop;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

endpackage
`default_nettype wire

// File: rtl/hazard_detect.sv
`default_nettype none
// ============================================================================
// Module : hazard_detect
// Desc   : Combinational load-use hazard detection and upstream stall.
// Rev    : 1.0
// ============================================================================
module hazard_detect #(
    parameter int REGW = 5
) (
    input  logic            id_valid,
    input  logic [REGW-1:0] id_rs1,
    input  logic [REGW-1:0] id_rs2,
    input  logic            id_alusrc,
    input  logic            id_memwrite,
    input  logic            id_jalsel,
    input  logic            id_jalrsel,
    input  logic [1:0]      id_aluop,
    input  logic            ex_valid,
    input  logic            ex_memread,
    input  logic [REGW-1:0] ex_rd,
    input  logic            flush_i,
    input  logic            ex_hold_i,
    output logic            load_use,
    output logic            stall_o
);
    import pipeline_pkg::*;

    logic rs1_used;
    logic rs2_used;

    // LUI and JAL carry no rs1; stores read rs2 even though ALUSrc selects imm
    assign rs1_used = !(id_aluop == ALUOP_LUI) && !(id_jalsel && !id_jalrsel);
    assign rs2_used = (!id_alusrc && !id_jalsel) || id_memwrite;

    assign load_use = id_valid && ex_valid && ex_memread && (ex_rd != '0) &&
                      ((rs1_used && (ex_rd == id_rs1)) ||
                       (rs2_used && (ex_rd == id_rs2)));

    assign stall_o = ex_hold_i || (load_use && !flush_i);

endmodule
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module : id_ex_stage
// Desc   : ID/EX pipeline register with load-use bubble, flush and hold.
//          Optional counters enabled by ID_EX_PERF_CNT_EN.
// Rev    : 1.0
// ============================================================================
module id_ex_stage #(
    parameter int XLEN = pipeline_pkg::XLEN,
    parameter int REGW = pipeline_pkg::REGW
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            id_valid,
    input  logic            id_alusrc,
    input  logic            id_memtoreg,
    input  logic            id_regwrite,
    input  logic            id_memread,
    input  logic            id_memwrite,
    input  logic            id_branch,
    input  logic            id_jalsel,
    input  logic            id_jalrsel,
    input  logic [1:0]      id_aluop,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_rd1,
    input  logic [XLEN-1:0] id_rd2,
    input  logic [XLEN-1:0] id_imm,
    input  logic [REGW-1:0] id_rs1,
    input  logic [REGW-1:0] id_rs2,
    input  logic [REGW-1:0] id_rd,
    input  logic [2:0]      id_funct3,
    input  logic [6:0]      id_funct7,
    input  logic            flush_i,
    input  logic            ex_hold_i,
    output logic            ex_valid,
    output logic            ex_alusrc,
    output logic            ex_memtoreg,
    output logic            ex_regwrite,
    output logic            ex_memread,
    output logic            ex_memwrite,
    output logic            ex_branch,
    output logic            ex_jalsel,
    output logic            ex_jalrsel,
    output logic [1:0]      ex_aluop,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_rd1,
    output logic [XLEN-1:0] ex_rd2,
    output logic [XLEN-1:0] ex_imm,
    output logic [REGW-1:0] ex_rs1,
    output logic [REGW-1:0] ex_rs2,
    output logic [REGW-1:0] ex_rd,
    output logic [2:0]      ex_funct3,
    output logic [6:0]      ex_funct7,
`ifdef ID_EX_PERF_CNT_EN
    output logic [31:0]     bubble_cnt,
    output logic [31:0]     flush_cnt,
`endif
    output logic            stall_o
);
    import pipeline_pkg::*;

    ctrl_t id_ctrl;
    ctrl_t ex_ctrl;
    logic  load_use;

    // An invalid slot is turned into a bubble so it can never write state
    always_comb begin
        id_ctrl = CTRL_BUBBLE;
        if (id_valid) begin
            id_ctrl.valid    = 1'b1;
            id_ctrl.alusrc   = id_alusrc;
            id_ctrl.memtoreg = id_memtoreg;
            id_ctrl.regwrite = id_regwrite;
            id_ctrl.memread  = id_memread;
            id_ctrl.memwrite = id_memwrite;
            id_ctrl.branch   = id_branch;
            id_ctrl.jalsel   = id_jalsel;
            id_ctrl.jalrsel  = id_jalrsel;
            id_ctrl.aluop    = id_aluop;
        end
    end

    hazard_detect #(
        .REGW (REGW)
    ) u_hazard_detect (
        .id_valid    (id_valid),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_alusrc   (id_alusrc),
        .id_memwrite (id_memwrite),
        .id_jalsel   (id_jalsel),
        .id_jalrsel  (id_jalrsel),
        .id_aluop    (id_aluop),
        .ex_valid    (ex_ctrl.valid),
        .ex_memread  (ex_ctrl.memread),
        .ex_rd       (ex_rd),
        .flush_i     (flush_i),
        .ex_hold_i   (ex_hold_i),
        .load_use    (load_use),
        .stall_o     (stall_o)
    );

    always_ff @(posedge clk) begin
        if (reset || flush_i) begin
            ex_ctrl   <= CTRL_BUBBLE;
            ex_pc     <= '0;
            ex_rd1    <= '0;
            ex_rd2    <= '0;
            ex_imm    <= '0;
            ex_rs1    <= '0;
            ex_rs2    <= '0;
            ex_rd     <= '0;
            ex_funct3 <= '0;
            ex_funct7 <= '0;
        end else if (!ex_hold_i) begin
            if (load_use) begin
                // Data fields are don't-care under a bubble; leave them alone
                ex_ctrl <= CTRL_BUBBLE;
            end else begin
                ex_ctrl   <= id_ctrl;
                ex_pc     <= id_pc;
                ex_rd1    <= id_rd1;
                ex_rd2    <= id_rd2;
                ex_imm    <= id_imm;
                ex_rs1    <= id_rs1;
                ex_rs2    <= id_rs2;
                ex_rd     <= id_rd;
                ex_funct3 <= id_funct3;
                ex_funct7 <= id_funct7;
            end
        end
    end

    assign ex_valid    = ex_ctrl.valid;
    assign ex_alusrc   = ex_ctrl.alusrc;
    assign ex_memtoreg = ex_ctrl.memtoreg;
    assign ex_regwrite = ex_ctrl.regwrite;
    assign ex_memread  = ex_ctrl.memread;
    assign ex_memwrite = ex_ctrl.memwrite;
    assign ex_branch   = ex_ctrl.branch;
    assign ex_jalsel   = ex_ctrl.jalsel;
    assign ex_jalrsel  = ex_ctrl.jalrsel;
    assign ex_aluop    = ex_ctrl.aluop;

`ifdef ID_EX_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            bubble_cnt <= '0;
            flush_cnt  <= '0;
        end else begin
            if (flush_i && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + 32'd1;
            end
            if (!flush_i && !ex_hold_i && load_use && (bubble_cnt != '1)) begin
                bubble_cnt <= bubble_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module : tb_id_ex_stage
// Desc   : Table-driven scoreboard bench for id_ex_stage.
// Rev    : 1.0
// ============================================================================
module tb_id_ex_stage;

    localparam int K_LOAD  = 0;
    localparam int K_BUB   = 1;
    localparam int K_FLUSH = 2;
    localparam int K_HOLD  = 3;
    localparam int NV      = 34;

    // {valid, alusrc, memtoreg, regwrite, memread, memwrite, branch, jalsel, jalrsel, aluop}
    localparam logic [10:0] C_LW   = 11'b1_1_1_1_1_0_0_0_0_00;
    localparam logic [10:0] C_ADD  = 11'b1_0_0_1_0_0_0_0_0_10;
    localparam logic [10:0] C_ADDI = 11'b1_1_0_1_0_0_0_0_0_10;
    localparam logic [10:0] C_LUI  = 11'b1_1_0_1_0_0_0_0_0_11;
    localparam logic [10:0] C_SW   = 11'b1_1_0_0_0_1_0_0_0_00;
    localparam logic [10:0] C_BEQ  = 11'b1_0_0_0_0_0_1_0_0_01;
    localparam logic [10:0] C_JAL  = 11'b1_1_0_1_0_0_0_1_0_01;
    localparam logic [10:0] C_JALR = 11'b1_1_0_1_0_0_0_1_1_01;
    localparam logic [10:0] NOVAL  = 11'b0_1_1_1_1_1_1_1_1_11;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        id_valid, id_alusrc, id_memtoreg, id_regwrite, id_memread;
    logic        id_memwrite, id_branch, id_jalsel, id_jalrsel;
    logic [1:0]  id_aluop;
    logic [31:0] id_pc, id_rd1, id_rd2, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [2:0]  id_funct3;
    logic [6:0]  id_funct7;
    logic        flush_i, ex_hold_i;
    logic        ex_valid, ex_alusrc, ex_memtoreg, ex_regwrite, ex_memread;
    logic        ex_memwrite, ex_branch, ex_jalsel, ex_jalrsel;
    logic [1:0]  ex_aluop;
    logic [31:0] ex_pc, ex_rd1, ex_rd2, ex_imm;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [2:0]  ex_funct3;
    logic [6:0]  ex_funct7;
    logic        stall_o;
`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] bubble_cnt, flush_cnt;
`endif

    id_ex_stage dut (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_alusrc(id_alusrc), .id_memtoreg(id_memtoreg), .id_regwrite(id_regwrite),
        .id_memread(id_memread), .id_memwrite(id_memwrite), .id_branch(id_branch),
        .id_jalsel(id_jalsel), .id_jalrsel(id_jalrsel), .id_aluop(id_aluop),
        .id_pc(id_pc), .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_funct3(id_funct3), .id_funct7(id_funct7),
        .flush_i(flush_i), .ex_hold_i(ex_hold_i),
        .ex_valid(ex_valid), .ex_alusrc(ex_alusrc), .ex_memtoreg(ex_memtoreg),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
        .ex_branch(ex_branch), .ex_jalsel(ex_jalsel), .ex_jalrsel(ex_jalrsel),
        .ex_aluop(ex_aluop), .ex_pc(ex_pc), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2),
        .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_funct3(ex_funct3), .ex_funct7(ex_funct7),
`ifdef ID_EX_PERF_CNT_EN
        .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt),
`endif
        .stall_o(stall_o)
    );

    logic [10:0]  act_ctrl;
    logic [152:0] act_data;
    assign act_ctrl = {ex_valid, ex_alusrc, ex_memtoreg, ex_regwrite, ex_memread,
                       ex_memwrite, ex_branch, ex_jalsel, ex_jalrsel, ex_aluop};
    assign act_data = {ex_pc, ex_rd1, ex_rd2, ex_imm, ex_rs1, ex_rs2, ex_rd,
                       ex_funct3, ex_funct7};

    typedef struct {
        logic [10:0] ctrl;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        flush;
        logic        hold;
        logic        exp_stall;
        int          kind;
    } vec_t;

    typedef struct {
        logic [10:0]  ctrl;
        logic [152:0] data;
        bit           chk_data;
    } exp_t;

    vec_t tbl [NV];
    exp_t sb [$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mkv(input logic [10:0] c, input logic [4:0] rd,
                                 input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic fl, input logic hd, input logic st,
                                 input int k);
        vec_t v;
        v.ctrl = c; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
        v.flush = fl; v.hold = hd; v.exp_stall = st; v.kind = k;
        return v;
    endfunction

    task automatic drive(input logic [10:0] c, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2,
                         input int i, input logic fl, input logic hd,
                         output logic [152:0] d);
        logic [31:0] iv;
        iv = i;
        {id_valid, id_alusrc, id_memtoreg, id_regwrite, id_memread,
         id_memwrite, id_branch, id_jalsel, id_jalrsel, id_aluop} = c;
        id_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
        id_pc     = 32'h0000_1000 + (iv << 2);
        id_rd1    = 32'hA5A5_0000 ^ iv;
        id_rd2    = 32'h5A5A_0000 + (iv * 32'd3);
        id_imm    = 32'hC000_0000 | iv;
        id_funct3 = iv[2:0];
        id_funct7 = iv[6:0] ^ 7'h55;
        flush_i   = fl;
        ex_hold_i = hd;
        d = {id_pc, id_rd1, id_rd2, id_imm, id_rs1, id_rs2, id_rd, id_funct3, id_funct7};
    endtask

    initial begin
        logic [152:0] d;
        exp_t e, prev, got;

        tbl[0]  = mkv(C_LW,   5'd5,  5'd1, 5'd0, 1'b0, 1'b0, 1'b0, K_LOAD);
        tbl[1]  = mkv(C_ADD,  5'd8,  5'd5, 5'd3, 1'b0, 1'b0, 1'b1, K_BUB);
        tbl[2]  = mkv(C_ADD,  5'd8,  5'd5, 5'd3, 1'b0, 1'b0, 1'b0, K_LOAD);
        tbl[3]  = mkv(C_LW,   5'd0,  5'd2, 5'd0, 1'b0, 1'b0, 1'b0, K_LOAD);
        tbl[4]  = mkv(C_ADD,  5'd9,  5'd0, 5'd0, 1'b0, 1'b0, 1'b0, K_LOAD);
        tbl[5]  = mkv(C_LW,   5'd5,  5'd1, 5'd0, 1'b0, 1'b0, 1'b0, K_LOAD);
        tbl[6]  = mkv(C_LUI,  5'd7,  5'd5, 5'd1, 1'b0, 1'b0, 1'b0, K_LOAD);
        tbl[7]  = mkv(C_LW,   5'd5,  5'd1, 5'd0, 1'b0, 1'b0, 1'b0, K_LOAD);
        tbl[8]  = mkv(C_ADDI, 5'd10, 5'd2, 5'd5, 1'b0, 1'b0, 1'b0, K_LOAD);
        tbl[9]  = mkv(C_LW,   5'd6,  5'd1, 5'd0, 1'b0, 1'b0, 1'b0, K_LOAD);
        tbl[10] = mkv(C_SW,   5'd0,  5'd2, 5'd6, 1'b0, 1'b0, 1'b1, K_BUB);
        tbl[11] = mkv(C_SW,   5'd0,  5'd2, 5'd6, 1'b0, 1'b0, 1'b0, K_LOAD);
        tbl[12] = mkv(C_LW,   5'd5,  5'd1, 5'd0, 1'b0, 1'b0, 1'b0, K_LOAD);
        tbl[13] = mkv(C_ADD,  5'd8,  5'd5, 5'd3, 1'b1, 1'b1, 1'b1, K_FLUSH);
        tbl[14] = mkv(C_LW,   5'd5,  5'd1, 5'd0, 1'b0, 1'b0, 1'b0, K_LOAD);
        tbl[15] = mkv(C_ADD,  5'd8,  5'd5, 5'd3, 1'b1, 1'b0, 1'b0, K_FLUSH);
        tbl[16] = mkv(C_LW,   5'd5,  5'd1, 5'd0, 1'b0, 1'b0, 1'b0, K_LOAD);
        tbl[17] = mkv(C_ADD,  5'd11, 5'd5, 5'd3, 1'b0, 1'b1, 1'b1, K_HOLD);
        tbl[18] = mkv(C_BEQ,  5'd0,  5'd4, 5'd7, 1'b0, 1'b1, 1'b1, K_HOLD);
        tbl[19] = mkv(C_LUI,  5'd12, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, K_HOLD);
        tbl[20] = mkv(C_ADD,  5'd11, 5'd5, 5'd3, 1'b0, 1'b0, 1'b1, K_BUB);
        tbl[21] = mkv(C_ADD,  5'd11, 5'd5, 5'd3, 1'b0, 1'b0, 1'b0, K_LOAD);
        tbl[22] = mkv(C_LW & NOVAL, 5'd5, 5'd1, 5'd0, 1'b0, 1'b0, 1'b0, K_LOAD);
        tbl[23] = mkv(C_ADD,  5'd8,  5'd5, 5'd3, 1'b0, 1'b0, 1'b0, K_LOAD);
        tbl[24] = mkv(C_LW,   5'd5,  5'd1, 5'd0, 1'b0, 1'b0, 1'b0, K_LOAD);
        tbl[25] = mkv(C_ADD & NOVAL, 5'd8, 5'd5, 5'd3, 1'b0, 1'b0, 1'b0, K_LOAD);
        tbl[26] = mkv(C_LW,   5'd5,  5'd1, 5'd0, 1'b0, 1'b0, 1'b0, K_LOAD);
        tbl[27] = mkv(C_JAL,  5'd1,  5'd5, 5'd5, 1'b0, 1'b0, 1'b0, K_LOAD);
        tbl[28] = mkv(C_LW,   5'd5,  5'd1, 5'd0, 1'b0, 1'b0, 1'b0, K_LOAD);
        tbl[29] = mkv(C_JALR, 5'd1,  5'd5, 5'd0, 1'b0, 1'b0, 1'b1, K_BUB);
        tbl[30] = mkv(C_JALR, 5'd1,  5'd5, 5'd0, 1'b0, 1'b0, 1'b0, K_LOAD);
        tbl[31] = mkv(C_LW,   5'd7,  5'd1, 5'd0, 1'b0, 1'b0, 1'b0, K_LOAD);
        tbl[32] = mkv(C_ADD,  5'd13, 5'd1, 5'd7, 1'b0, 1'b0, 1'b1, K_BUB);
        tbl[33] = mkv(C_ADD,  5'd13, 5'd1, 5'd7, 1'b0, 1'b0, 1'b0, K_LOAD);

        // Reset held for two edges while ID presents a real, register-writing op
        reset = 1'b1;
        drive(C_ADD, 5'd3, 5'd1, 5'd2, 99, 1'b0, 1'b0, d);
        for (int r = 0; r < 2; r++) begin
            @(posedge clk); #1;
            chk($sformatf("reset ctrl e%0d", r), 256'(act_ctrl), 256'(11'd0));
            chk($sformatf("reset data e%0d", r), 256'(act_data), 256'(153'd0));
            chk($sformatf("reset stall e%0d", r), 256'(stall_o), 256'(1'b0));
        end
`ifdef ID_EX_PERF_CNT_EN
        chk("reset bubble_cnt", 256'(bubble_cnt), 256'(32'd0));
        chk("reset flush_cnt", 256'(flush_cnt), 256'(32'd0));
`endif
        @(negedge clk);
        reset = 1'b0;

        prev.ctrl = '0; prev.data = '0; prev.chk_data = 1'b1;
        for (int i = 0; i < NV; i++) begin
            if (i != 0) @(negedge clk);
            drive(tbl[i].ctrl, tbl[i].rd, tbl[i].rs1, tbl[i].rs2, i,
                  tbl[i].flush, tbl[i].hold, d);
            e.chk_data = 1'b1;
            case (tbl[i].kind)
                K_LOAD:  begin e.ctrl = tbl[i].ctrl[10] ? tbl[i].ctrl : 11'd0; e.data = d; end
                K_BUB:   begin e.ctrl = '0; e.data = prev.data; e.chk_data = 1'b0; end
                K_FLUSH: begin e.ctrl = '0; e.data = '0; end
                default: e = prev;
            endcase
            sb.push_back(e);
            prev = e;
            #1;
            chk($sformatf("stall_o v%0d", i), 256'(stall_o), 256'(tbl[i].exp_stall));
            @(posedge clk); #1;
            if (sb.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL scoreboard v%0d: got empty queue expected entry", i);
            end else begin
                got = sb.pop_front();
                chk($sformatf("ex ctrl v%0d", i), 256'(act_ctrl), 256'(got.ctrl));
                if (got.chk_data)
                    chk($sformatf("ex data v%0d", i), 256'(act_data), 256'(got.data));
            end
        end

`ifdef ID_EX_PERF_CNT_EN
        chk("bubble_cnt", 256'(bubble_cnt), 256'(32'd5));
        chk("flush_cnt", 256'(flush_cnt), 256'(32'd2));
`endif

        // Reset arriving while a load-use stall is pending
        @(negedge clk);
        drive(C_LW, 5'd5, 5'd1, 5'd0, 200, 1'b0, 1'b0, d);
        @(negedge clk);
        drive(C_ADD, 5'd8, 5'd5, 5'd3, 201, 1'b0, 1'b0, d);
        #1;
        chk("midstall stall before", 256'(stall_o), 256'(1'b1));
        reset = 1'b1;
        @(posedge clk); #1;
        chk("midstall ctrl", 256'(act_ctrl), 256'(11'd0));
        chk("midstall stall after", 256'(stall_o), 256'(1'b0));
`ifdef ID_EX_PERF_CNT_EN
        chk("midstall bubble_cnt", 256'(bubble_cnt), 256'(32'd0));
        chk("midstall flush_cnt", 256'(flush_cnt), 256'(32'd0));
`endif
        @(negedge clk);
        reset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
